// File: rtl/mesh_pkg.sv
// Shared types and helpers for the mesh terminal injector: packet field
// positions, destination legality check and header assembly.
package mesh_pkg;

  // Widest packet the helpers handle; callers narrow the result to pckg_sz.
  localparam int unsigned PktMaxW = 256;
  localparam int unsigned HdrW    = 17;

  typedef logic [PktMaxW-1:0] pkt_max_t;

  // Field positions as a function of the packet width.
  function automatic int unsigned nxtjp_msb(input int unsigned pckg_sz);
    return pckg_sz - 1;
  endfunction

  function automatic int unsigned row_msb(input int unsigned pckg_sz);
    return pckg_sz - 9;
  endfunction

  function automatic int unsigned col_msb(input int unsigned pckg_sz);
    return pckg_sz - 13;
  endfunction

  function automatic int unsigned mode_bit(input int unsigned pckg_sz);
    return pckg_sz - 17;
  endfunction

  function automatic int unsigned payload_msb(input int unsigned pckg_sz);
    return pckg_sz - 18;
  endfunction

  // A terminal may only address the ring of external ports or broadcast.
  function automatic logic is_legal_dest(input logic [3:0]  row,
                                         input logic [3:0]  colum,
                                         input int unsigned rows,
                                         input int unsigned colums,
                                         input logic [7:0]  bdcst);
    int unsigned r;
    int unsigned c;
    logic        row_edge;
    logic        col_edge;
    r        = 32'(row);
    c        = 32'(colum);
    row_edge = ((r == 32'd0) || (r == rows + 32'd1)) && (c >= 32'd1) && (c <= colums);
    col_edge = ((c == 32'd0) || (c == colums + 32'd1)) && (r >= 32'd1) && (r <= rows);
    return row_edge || col_edge || ({row, colum} == bdcst);
  endfunction

  // Payload must arrive zero-extended; Nxtjp is always zero on injection.
  function automatic pkt_max_t build_pkt(input logic [3:0]  row,
                                         input logic [3:0]  colum,
                                         input logic        mode,
                                         input pkt_max_t    payload,
                                         input int unsigned pckg_sz);
    pkt_max_t hdr;
    hdr = pkt_max_t'({8'h00, row, colum, mode});
    return (hdr << mode_bit(pckg_sz)) | payload;
  endfunction

endpackage

// File: rtl/mesh_term_injector_if.sv
// Client write port, mesh-side pop handshake and status of one injector.
interface mesh_term_injector_if #(
  parameter int unsigned pckg_sz    = 40,
  parameter int unsigned fifo_depth = 4
) ();

  logic                               wr_vld;
  logic                               wr_rdy;
  logic [3:0]                         wr_row;
  logic [3:0]                         wr_colum;
  logic                               wr_mode;
  logic [pckg_sz-18:0]                wr_payload;
  logic                               pndng_i_in;
  logic [pckg_sz-1:0]                 data_out_i_in;
  logic                               popin;
  logic [$clog2(fifo_depth+1)-1:0]    occupancy;
  logic [7:0]                         drop_cnt;
  logic                               err_underflow;

  // Client and mesh side.
  modport master (
    output wr_vld, wr_row, wr_colum, wr_mode, wr_payload, popin,
    input  wr_rdy, pndng_i_in, data_out_i_in, occupancy, drop_cnt, err_underflow
  );

  // Injector side.
  modport slave (
    input  wr_vld, wr_row, wr_colum, wr_mode, wr_payload, popin,
    output wr_rdy, pndng_i_in, data_out_i_in, occupancy, drop_cnt, err_underflow
  );

endinterface

// File: rtl/mesh_sync_fifo.sv
// First-word-fall-through FIFO with a dedicated registered head word.
// Pointers wrap modulo DEPTH, so non-power-of-two depths are supported.
module mesh_sync_fifo #(
  parameter int unsigned WIDTH = 40,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       valid_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             empty;
  logic             do_push;
  logic             do_pop;
  logic [PtrW-1:0]  rd_nxt;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (cnt_q == '0);
  assign full_o  = (cnt_q == CntW'(DEPTH));
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty;
  assign rd_nxt  = ptr_inc(rd_ptr_q);
  assign valid_o = !empty;
  assign count_o = cnt_q;
  assign rdata_o = head_q;

  // Next pointers, count and head word; head holds its value when empty.
  always_comb begin
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_nxt : rd_ptr_q;
    cnt_d    = cnt_q + CntW'(do_push) - CntW'(do_pop);
    head_d   = head_q;
    if (do_pop) begin
      // Entry behind the head already stored, or the word arriving now.
      if (cnt_q > CntW'(1)) begin
        head_d = mem_q[rd_nxt];
      end else if (do_push) begin
        head_d = wdata_i;
      end
    end else if (do_push && empty) begin
      head_d = wdata_i;
    end
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      head_q   <= head_d;
    end
  end

  // Storage array; contents are qualified by the count so need no reset.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/mesh_term_injector.sv
// Terminal-side packet injector: assembles the router header, filters illegal
// destinations and queues legal packets toward one mesh input port.
module mesh_term_injector
  import mesh_pkg::*;
#(
  parameter int unsigned ROWS       = 4,
  parameter int unsigned COLUMS     = 4,
  parameter int unsigned pckg_sz    = 40,
  parameter int unsigned fifo_depth = 4,
  parameter logic [7:0]  bdcst      = 8'hFF
) (
  input logic                  clk,
  input logic                  reset,
  mesh_term_injector_if.slave  bus
);

  logic               full;
  logic               legal;
  logic               accept;
  logic               push;
  logic               pndng;
  logic [pckg_sz-1:0] wdata;
  logic [7:0]         drop_q, drop_d;
  logic               err_q, err_d;

  assign legal  = is_legal_dest(bus.wr_row, bus.wr_colum, ROWS, COLUMS, bdcst);
  assign wdata  = pckg_sz'(build_pkt(bus.wr_row, bus.wr_colum, bus.wr_mode,
                                     pkt_max_t'(bus.wr_payload), pckg_sz));
  // Ready comes from the registered count only, so popin never reaches it.
  assign bus.wr_rdy = !full;
  assign accept     = bus.wr_vld && !full;
  assign push       = accept && legal;

  mesh_sync_fifo #(
    .WIDTH (pckg_sz),
    .DEPTH (fifo_depth)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .push_i  (push),
    .wdata_i (wdata),
    .pop_i   (bus.popin),
    .rdata_o (bus.data_out_i_in),
    .valid_o (pndng),
    .count_o (bus.occupancy),
    .full_o  (full)
  );

  assign bus.pndng_i_in    = pndng;
  assign bus.drop_cnt      = drop_q;
  assign bus.err_underflow = err_q;

  // Saturating drop count and sticky underflow flag.
  always_comb begin
    drop_d = drop_q;
    err_d  = err_q;
    if (accept && !legal && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end
    if (bus.popin && !pndng) begin
      err_d = 1'b1;
    end
  end

  // Status registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_q <= '0;
      err_q  <= 1'b0;
    end else begin
      drop_q <= drop_d;
      err_q  <= err_d;
    end
  end

endmodule
